// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: sequencer for the core clock/reset generator.
//
// Accepts a reconfiguration request and walks the generator through
// IDLE -> HOLD -> BYPASS -> PROG -> SWITCH -> RELEASE -> IDLE. The core is
// held in reset, its clock is parked on sys_clk, the PLL is reprogrammed and
// given time to lock, then the clock mux is switched and the core released.
// The core therefore never runs on an unsettled PLL clock or a mux glitch.
//
// Parameters:
//   SETTLE_CYCLES  cycles in each of HOLD, BYPASS and SWITCH (1..2^20-1)
//   LOCK_CYCLES    cycles in PROG waiting for PLL lock (1..2^20-1)
//   RESET_CFG      pll_cfg value after reset
//
// Ports:
//   sys_clk, sys_rst_n     clock; asynchronous active-low reset
//   req_valid/req_ready    request handshake; accepted when both are high
//   req_cfg, req_use_pll   request payload, latched on accept
//   pll_cfg, clk_sel       registered controls to the clock generator
//   core_hold_n            registered active-low core hold
//   busy, done             status; done is a one-cycle completion pulse
//   seq_state              current sequencer state, for observation
//
// Handshake: a request transfers on a rising sys_clk edge where req_valid
// and req_ready are both high. req_ready is high only in IDLE; requests seen
// while busy are dropped, never queued.
//
// Optional feature macro: PLL_SEQ_FASTPATH_EN. When defined, a request whose
// req_cfg equals the current pll_cfg skips BYPASS and PROG
// (IDLE -> HOLD -> SWITCH -> RELEASE). When undefined, every request runs
// the full sequence.

module pll_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_CYCLES   = 16,
  parameter logic [2:0]  RESET_CFG     = 3'b000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_cfg,
  input  logic       req_use_pll,
  output logic [2:0] pll_cfg,
  output logic       clk_sel,
  output logic       core_hold_n,
  output logic       busy,
  output logic       done,
  output logic [2:0] seq_state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_BYPASS  = 3'd2;
  localparam logic [2:0] ST_PROG    = 3'd3;
  localparam logic [2:0] ST_SWITCH  = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  // Counter runs 0..N-1 inside a state; these are the exit values.
  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);
  localparam logic [19:0] LOCK_LAST   = 20'(LOCK_CYCLES - 1);

  logic [2:0]  state;
  logic [19:0] cnt;
  logic [2:0]  lat_cfg;
  logic        lat_use_pll;
`ifdef PLL_SEQ_FASTPATH_EN
  logic        fast;
`endif

  assign seq_state = state;

  // Every output is a register that is written on the edge that enters the
  // state it belongs to, so each change is visible in that state's first cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 20'd0;
      lat_cfg     <= RESET_CFG;
      lat_use_pll <= 1'b0;
`ifdef PLL_SEQ_FASTPATH_EN
      fast        <= 1'b0;
`endif
      pll_cfg     <= RESET_CFG;
      clk_sel     <= 1'b0;
      core_hold_n <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            lat_cfg     <= req_cfg;
            lat_use_pll <= req_use_pll;
`ifdef PLL_SEQ_FASTPATH_EN
            fast        <= (req_cfg == pll_cfg);
`endif
            state       <= ST_HOLD;
            cnt         <= 20'd0;
            core_hold_n <= 1'b0;
            busy        <= 1'b1;
            req_ready   <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= 20'd0;
`ifdef PLL_SEQ_FASTPATH_EN
            // PLL already carries the requested config: no need to park
            // the clock or reprogram, go straight to the mux switch.
            if (fast) begin
              state   <= ST_SWITCH;
              clk_sel <= lat_use_pll;
            end else
`endif
            begin
              state   <= ST_BYPASS;
              clk_sel <= 1'b0;
            end
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        ST_BYPASS: begin
          if (cnt == SETTLE_LAST) begin
            cnt     <= 20'd0;
            state   <= ST_PROG;
            // clk_sel has been 0 for the whole of BYPASS, so the PLL is
            // reprogrammed only while the core runs from sys_clk.
            pll_cfg <= lat_cfg;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        ST_PROG: begin
          if (cnt == LOCK_LAST) begin
            cnt     <= 20'd0;
            state   <= ST_SWITCH;
            clk_sel <= lat_use_pll;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        ST_SWITCH: begin
          if (cnt == SETTLE_LAST) begin
            cnt         <= 20'd0;
            state       <= ST_RELEASE;
            core_hold_n <= 1'b1;
            done        <= 1'b1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        ST_RELEASE: begin
          state     <= ST_IDLE;
          cnt       <= 20'd0;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state       <= ST_IDLE;
          cnt         <= 20'd0;
          core_hold_n <= 1'b1;
          done        <= 1'b0;
          busy        <= 1'b0;
          req_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Testbench for pll_seq_ctrl. Directed scenarios followed by randomized
// requests; a cycle-level reference model derived from the sequence timing
// table predicts every output, and a queue of expected completions is
// matched against done pulses by an independent monitor.
// Honours PLL_SEQ_FASTPATH_EN the same way the design does.

module tb_pll_seq_ctrl;

  localparam int         S    = 4;
  localparam int         L    = 16;
  localparam logic [2:0] RCFG = 3'b000;
  localparam int         W    = 20;

  logic       clk;
  logic       sys_rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_cfg;
  logic       req_use_pll;
  logic [2:0] pll_cfg;
  logic       clk_sel;
  logic       core_hold_n;
  logic       busy;
  logic       done;
  logic [2:0] seq_state;

  pll_seq_ctrl #(
    .SETTLE_CYCLES(S),
    .LOCK_CYCLES  (L),
    .RESET_CFG    (RCFG)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cfg    (req_cfg),
    .req_use_pll(req_use_pll),
    .pll_cfg    (pll_cfg),
    .clk_sel    (clk_sel),
    .core_hold_n(core_hold_n),
    .busy       (busy),
    .done       (done),
    .seq_state  (seq_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];   // {done cycle[15:0], pll_cfg, clk_sel} at done

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Sequence defined by offsets from the accept cycle a0:
  //   full: HOLD 1..S, BYPASS S+1..2S, PROG 2S+1..2S+L, SWITCH ..3S+L,
  //         RELEASE 3S+L+1
  //   fast: HOLD 1..S, SWITCH S+1..2S, RELEASE 2S+1
  bit         m_active = 1'b0;
  int         m_a0     = 0;
  bit         m_fast   = 1'b0;
  logic [2:0] m_lat_cfg = RCFG;
  logic       m_lat_sel = 1'b0;
  logic [2:0] m_cfg    = RCFG;
  logic       m_sel    = 1'b0;

  always @(negedge clk) begin : model
    int k;
    int rel;
    logic [7:0] exp_v;
    logic [7:0] act_v;
    logic m_hold;
    logic m_done;
    act_v = {req_ready, busy, done, core_hold_n, clk_sel, pll_cfg};
    if (!sys_rst_n) begin
      m_active = 1'b0;
      m_cfg    = RCFG;
      m_sel    = 1'b0;
      exp_q.delete();
      exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RCFG};
      check("reset_outputs", 32'(act_v), 32'(exp_v));
    end else begin
      if (m_active) begin
        k   = cyc - m_a0;
        rel = m_fast ? (2*S + 1) : (3*S + L + 1);
        if (m_fast) begin
          if (k == S + 1) m_sel = m_lat_sel;
        end else begin
          if (k == S + 1)       m_sel = 1'b0;
          if (k == 2*S + 1)     m_cfg = m_lat_cfg;
          if (k == 2*S + L + 1) m_sel = m_lat_sel;
        end
        m_hold = (k == rel);
        m_done = (k == rel);
        exp_v  = {1'b0, 1'b1, m_done, m_hold, m_sel, m_cfg};
        if (k == rel) m_active = 1'b0;
      end else begin
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, m_sel, m_cfg};
      end
      check("cycle_outputs", 32'(act_v), 32'(exp_v));
      // Accept happens on the coming edge when idle and a request is present.
      if (exp_v[7] && req_valid) begin
        m_active  = 1'b1;
        m_a0      = cyc;
        m_lat_cfg = req_cfg;
        m_lat_sel = req_use_pll;
`ifdef PLL_SEQ_FASTPATH_EN
        m_fast    = (req_cfg == m_cfg);
`else
        m_fast    = 1'b0;
`endif
        rel = m_fast ? (2*S + 1) : (3*S + L + 1);
        exp_q.push_back({16'(cyc + rel), (m_fast ? m_cfg : req_cfg), req_use_pll});
      end
    end
  end

  // ---------------- done monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (sys_rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_event", 32'({16'(cyc), pll_cfg, clk_sel}), 32'(e));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] cfg, input logic use_pll);
    req_valid   = 1'b1;
    req_cfg     = cfg;
    req_use_pll = use_pll;
  endtask

  initial begin : driver
    int idle;
    int hold;
    sys_rst_n   = 1'b0;
    req_valid   = 1'b0;
    req_cfg     = 3'b000;
    req_use_pll = 1'b0;
    repeat (3) step();
    sys_rst_n = 1'b1;
    repeat (6) step();

    // Full sequence, cfg 101 onto PLL; accept at cycle a0.
    issue(3'b101, 1'b1);
    step();                   // a0+1
    req_valid = 1'b0;
    repeat (8) step();        // a0+9
    check("prog_cfg_c9", 32'(pll_cfg), 32'h5);
    check("hold_c9", 32'(core_hold_n), 32'h0);
    repeat (16) step();       // a0+25
    check("switch_sel_c25", 32'(clk_sel), 32'h1);
    repeat (4) step();        // a0+29
    check("done_c29", 32'({done, core_hold_n}), 32'h3);
    step();                   // a0+30
    check("ready_c30", 32'(req_ready), 32'h1);

    // Same cfg again: fast path when enabled, full sequence otherwise.
    issue(3'b101, 1'b1);
    step();
    req_valid = 1'b0;
    repeat (8) step();        // a0+9
`ifdef PLL_SEQ_FASTPATH_EN
    check("fast_done_c9", 32'(done), 32'h1);
`else
    check("full_nodone_c9", 32'(done), 32'h0);
`endif
    check("fast_cfg_kept", 32'(pll_cfg), 32'h5);
    repeat (22) step();

    // use_pll=0 request, reset in PROG at cycle 12.
    issue(3'b010, 1'b0);
    step();
    req_valid = 1'b0;
    repeat (11) step();       // a0+12
    #1 sys_rst_n = 1'b0;
    #1 check("async_reset", 32'({req_ready, busy, done, core_hold_n, clk_sel, pll_cfg}),
             32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RCFG}));
    repeat (2) step();
    sys_rst_n = 1'b1;
    step();
    issue(3'b110, 1'b0);
    step();
    req_valid = 1'b0;
    repeat (34) step();

    // req_valid held across a whole sequence: re-accept only when idle.
    issue(3'b011, 1'b1);
    repeat (40) step();
    req_valid = 1'b0;
    repeat (35) step();

    // Randomized requests, sometimes matching the current config.
    for (int i = 0; i < 30; i++) begin
      idle = $urandom_range(0, 5);
      repeat (idle) step();
      if ($urandom_range(0, 1) == 1) issue(m_cfg, 1'($urandom_range(0, 1)));
      else issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      hold = $urandom_range(1, 40);
      repeat (hold) step();
      req_valid = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 20)) step();
        #1 sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
      end
    end
    repeat (40) step();

    check("done_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
